// File: rtl/encoder_pkg.sv
//==============================================================================
// Module      : encoder_pkg
// Description : Shared types and constants for the streaming priority encoder.
//               Default line count/index width, the FIFO entry layout and the
//               output buffer depth.
//               Optional feature macro: ENCODER_ONEHOT_CHECK_EN (adds the err
//               bit to each buffered entry).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package encoder_pkg;

  localparam int ENC_N_DEFAULT  = 4;
  localparam int ENC_W_DEFAULT  = $clog2(ENC_N_DEFAULT);
  localparam int ENC_FIFO_DEPTH = 2;
  // Count must be able to represent 0..DEPTH inclusive.
  localparam int ENC_CNT_W      = $clog2(ENC_FIFO_DEPTH + 1);
  localparam int ENC_PTR_W      = $clog2(ENC_FIFO_DEPTH);

  // One buffered encode result. Without the one-hot check the err bit is not
  // stored at all; the top ties its err port low instead.
  typedef struct packed {
    logic [ENC_W_DEFAULT-1:0] a;
    logic                     z;
`ifdef ENCODER_ONEHOT_CHECK_EN
    logic                     err;
`endif
  } enc_entry_t;

endpackage

`default_nettype wire

// File: rtl/enc_fifo2.sv
//==============================================================================
// Module      : enc_fifo2
// Description : 2-entry synchronous FIFO of encoder results. Head entry is
//               read straight from the storage registers.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               push_i/wdata_i - write strobe and entry (ignored when full)
//               pop_i          - read strobe (ignored when empty)
//               full_o/empty_o - occupancy flags
//               count_o        - number of stored entries (0..2)
//               rdata_o        - head entry
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module enc_fifo2
  import encoder_pkg::*;
#(
  parameter type T = enc_entry_t
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push_i,
  input  T                     wdata_i,
  input  logic                 pop_i,
  output logic                 full_o,
  output logic                 empty_o,
  output logic [ENC_CNT_W-1:0] count_o,
  output T                     rdata_o
);

  T                     mem_q [ENC_FIFO_DEPTH];
  logic [ENC_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ENC_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ENC_CNT_W-1:0] count_q, count_d;
  logic                 w_push;
  logic                 w_pop;

  assign full_o  = (count_q == ENC_CNT_W'(ENC_FIFO_DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Guards make an over-push or under-pop a no-op rather than a corruption.
  assign w_push = push_i && !full_o;
  assign w_pop  = pop_i && !empty_o;

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_push) wr_ptr_d = wr_ptr_q + ENC_PTR_W'(1);
    if (w_pop)  rd_ptr_d = rd_ptr_q + ENC_PTR_W'(1);
    count_d = count_q + ENC_CNT_W'(w_push) - ENC_CNT_W'(w_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // Storage is cleared too so the head reads as all-zero after reset.
      for (int i = 0; i < ENC_FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) mem_q[wr_ptr_q] <= wdata_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/priority_encoder_stream.sv
//==============================================================================
// Module      : priority_encoder_stream
// Description : Streaming N-to-log2(N) priority encoder with valid/ready on
//               both sides and a 2-entry output buffer. Returns the index of
//               the highest set line of D plus an all-zero flag.
//               Optional feature macro: ENCODER_ONEHOT_CHECK_EN - when defined,
//               err flags inputs with more than one line set; otherwise err
//               is tied low.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               E                   - enable; low blocks acceptance only
//               in_valid/in_ready/D - input handshake and line vector
//               out_valid/out_ready - output handshake
//               A, Z, err           - head result (index, zero, multi-hot)
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module priority_encoder_stream
  import encoder_pkg::*;
#(
  parameter int N = ENC_N_DEFAULT,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         E,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] D,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] A,
  output logic         Z,
  output logic         err
);

  // Entry layout sized to this instance's index width.
  typedef struct packed {
    logic [W-1:0] a;
    logic         z;
`ifdef ENCODER_ONEHOT_CHECK_EN
    logic         err;
`endif
  } entry_t;

  entry_t               w_enc;
  entry_t               w_head;
  logic                 w_full;
  logic                 w_empty;
  logic [ENC_CNT_W-1:0] w_count;
  logic                 w_push;
  logic                 w_pop;

  // Ascending scan: the last set line wins, giving the highest index.
  always_comb begin
    w_enc   = '0;
    w_enc.z = (D == '0);
    for (int i = 0; i < N; i++) begin
      if (D[i]) w_enc.a = W'(i);
    end
`ifdef ENCODER_ONEHOT_CHECK_EN
    // Clearing the lowest set bit leaves something only if two or more were set.
    w_enc.err = |(D & (D - N'(1)));
`endif
  end

  // Ready never looks at out_ready, so there is no combinational path through.
  assign in_ready  = !rst && E && !w_full;
  assign w_push    = in_valid && in_ready;
  assign out_valid = (w_count != '0);
  assign w_pop     = out_ready && !w_empty;

  enc_fifo2 #(
    .T (entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_push),
    .wdata_i (w_enc),
    .pop_i   (w_pop),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (w_count),
    .rdata_o (w_head)
  );

  assign A = w_head.a;
  assign Z = w_head.z;
`ifdef ENCODER_ONEHOT_CHECK_EN
  assign err = w_head.err;
`else
  assign err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_priority_encoder_stream.sv
//==============================================================================
// Module      : tb_priority_encoder_stream
// Description : Self-checking bench for priority_encoder_stream (N=4).
//               Expected results are queued at acceptance and compared when
//               the DUT presents them. Honours ENCODER_ONEHOT_CHECK_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_priority_encoder_stream;

  localparam int N = 4;
  localparam int W = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         E;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] D;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] A;
  logic         Z;
  logic         err;

  priority_encoder_stream #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .E         (E),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .D         (D),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .A         (A),
    .Z         (Z),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic         z;
    logic         err;
  } exp_t;

  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t sb_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference encoder: descending scan, first hit wins.
  function automatic exp_t model(input logic [N-1:0] d);
    exp_t e;
    e.a = '0; e.z = 1'b1; e.err = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (d[i]) begin
        e.a = W'(i);
        e.z = 1'b0;
        break;
      end
    end
`ifdef ENCODER_ONEHOT_CHECK_EN
    e.err = ($countones(d) > 1);
`endif
    return e;
  endfunction

  // Monitor: at each falling edge, first apply the effect of the rising edge
  // just past (decided at the previous falling edge), then check, then decide.
  initial begin
    bit   started  = 0;
    bit   rst_p    = 0;
    bit   acc_p    = 0;
    bit   pop_p    = 0;
    bit   rst_edge = 0;
    int   cnt_m    = 0;
    exp_t e_p;
    exp_t h;
    forever begin
      @(negedge clk);
      if (rst_p) begin
        sb_q.delete();
        cnt_m    = 0;
        rst_edge = 1;
        started  = 1;
      end else begin
        rst_edge = 0;
        if (pop_p) void'(sb_q.pop_front());
        if (acc_p) sb_q.push_back(e_p);
        cnt_m = cnt_m + int'(acc_p) - int'(pop_p);
      end
      if (started) begin
        check("out_valid", out_valid, cnt_m != 0);
        check("in_ready", in_ready, !rst && E && (cnt_m < 2));
        if (rst_edge) begin
          check("rst_A", A, 0);
          check("rst_Z", Z, 0);
          check("rst_err", err, 0);
        end
      end
      pop_p = (cnt_m != 0) && (out_ready === 1'b1);
      acc_p = (in_valid === 1'b1) && (rst === 1'b0) && (E === 1'b1) && (cnt_m < 2);
      rst_p = (rst === 1'b1);
      if (started && pop_p) begin
        if (sb_q.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          h = sb_q[0];
          check("A", A, h.a);
          check("Z", Z, h.z);
          check("err", err, h.err);
        end
      end
      if (acc_p) e_p = model(D);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [N-1:0] sweep [4];
    sweep[0] = 4'b0001; sweep[1] = 4'b0010; sweep[2] = 4'b0100; sweep[3] = 4'b1000;

    // Reset with busy-looking inputs.
    rst = 1'b1; E = 1'b1; in_valid = 1'b1; D = 4'hF; out_ready = 1'b1;
    step(2);
    rst = 1'b0; in_valid = 1'b0;
    step(1);

    // One-hot sweep at full throughput.
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      D = sweep[i];
      step(1);
    end
    in_valid = 1'b0;
    step(2);

    // Zero input and multi-hot priority.
    in_valid = 1'b1; D = 4'b0000;
    step(1);
    D = 4'b1011;
    step(1);
    in_valid = 1'b0;
    step(2);

    // Backpressure: fill both entries, hold a third request, then drain.
    out_ready = 1'b0; in_valid = 1'b1; D = 4'b0100;
    step(1);
    D = 4'b0010;
    step(1);
    D = 4'b1000;
    step(3);
    in_valid = 1'b0; out_ready = 1'b1;
    step(3);

    // Enable low blocks acceptance while a buffered entry drains.
    out_ready = 1'b0; in_valid = 1'b1; D = 4'b0001;
    step(1);
    E = 1'b0; D = 4'b1000;
    step(3);
    out_ready = 1'b1;
    step(2);
    in_valid = 1'b0; E = 1'b1;
    step(1);

    // Reset while both entries are buffered.
    out_ready = 1'b0; in_valid = 1'b1; D = 4'b0010;
    step(1);
    D = 4'b1000;
    step(1);
    in_valid = 1'b0; rst = 1'b1;
    step(1);
    rst = 1'b0; out_ready = 1'b1;
    step(3);

    // Random traffic.
    for (int i = 0; i < 80; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 2) != 0);
      E         = 1'($urandom_range(0, 4) != 0);
      D         = N'($urandom);
      step(1);
    end

    // Drain with a bounded wait.
    in_valid = 1'b0; out_ready = 1'b1; E = 1'b1;
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) step(1);
    step(2);
    check("drain_timeout", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/priority_encoder_stream.md
# priority_encoder_stream

Streaming N-to-log2(N) priority encoder with valid/ready handshakes on both sides and a 2-entry output buffer. It is the inverse of the team's 2-to-4 enable-gated decoder: it takes a line vector D (decoder-output style) and returns the binary index A of the highest asserted line, plus a zero flag. It sits between request/interrupt lines and any index-consuming block that may apply backpressure.

## Interface
- N, default 4: number of input lines; power of two, 2..32
- W, default $clog2(N): index width
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- E  input  1  enable; E=0 blocks acceptance, buffered output still drains
- in_valid  input  1  D is valid
- in_ready  output  1  block accepts D this cycle
- D  input  N  input line vector; D[N-1] has highest priority
- out_valid  output  1  A/Z/err valid
- out_ready  input  1  consumer accepts output this cycle
- A  output  W  index of highest set bit of D; 0 when D==0
- Z  output  1  D was all-zero
- err  output  1  D had more than one bit set (see Configuration)

## Operation
- Accept on rising edge when in_valid && in_ready; encode D combinationally, push {A,Z,err} into 2-entry FIFO.
- Encode: A = max i with D[i]=1; D==0 gives A=0, Z=1; otherwise Z=0.
- in_ready = E && (fifo count < 2); no dependence on out_ready, so no combinational ready path.
- Pop when out_valid && out_ready; out_valid = (count != 0); A/Z/err show FIFO head, registered.
- Push and pop in the same cycle: count unchanged; head advances, new entry goes to tail; legal at count 1 only (count 0 cannot pop; count 2 cannot push).
- Output holds stable while out_valid && !out_ready.
- Entries are never dropped or reordered.
- E toggling never corrupts buffered entries.
- Reset: count=0, FIFO pointers 0, out_valid=0, A=0, Z=0, err=0, in_ready=0 during rst, then E-dependent; reset mid-transfer discards all buffered entries.

## Timing
- Latency: D accepted at edge k gives out_valid=1 with its result after edge k (visible in cycle k+1).
- Throughput: 1 result/cycle when out_ready held high and in_valid held high.
- With out_ready low: 2 accepts, then in_ready drops in the cycle after the second accept; it rises again in the cycle after the first pop.
- in_valid=1 while in_ready=0: D not consumed; source must hold D.

## Configuration
- ENCODER_ONEHOT_CHECK_EN defined: err = 1 when popcount(D) > 1 at acceptance; stored with the entry, presented with its A.
- Not defined: err tied 0; the FIFO entry omits the err bit; the port remains for interface stability.

## Structure
- Package encoder_pkg: N/W defaults, typedef enc_entry_t {A[W-1:0], Z, err}, FIFO depth constant ENC_FIFO_DEPTH=2.
- Sub-module enc_fifo2: 2-entry synchronous FIFO of enc_entry_t with push/pop/full/empty and count.
- Top: combinational priority encode, optional popcount check, enc_fifo2 instance, handshake glue.

## Test plan
- Reset: rst=1 for 2 cycles, any inputs -> out_valid=0, A=0, Z=0, err=0, in_ready=0; release with E=1 -> in_ready=1 next cycle.
- Sweep one-hot, N=4, out_ready=1: D=0001,0010,0100,1000 on consecutive cycles -> A=0,1,2,3 one cycle later each, Z=0, err=0, one result per cycle.
- Zero/priority: D=0000 -> A=0, Z=1; D=1011 -> A=3, err=1 with macro, err=0 without.
- Backpressure: out_ready=0, push D=0100 then 0010 -> in_ready=0 after second accept, out_valid held with A=2; raise out_ready -> A=2 then A=1, in_ready=1 again in the cycle after the first pop.
- Enable: E=0 with in_valid=1, D=1000 -> in_ready=0, nothing accepted; buffered entry still pops.
- Reset mid-operation: FIFO holding 2 entries, rst=1 one cycle -> out_valid=0 next cycle, entries lost, no stale output after release.
